// File: rtl/ram_bist_pkg.sv
// Shared types and the data-pattern generator for the RAM write/read-back exerciser.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        FLUSH,
        DONE
    } state_t;

    localparam logic [1:0] MODE_ADDR = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_CHK  = 2'd2;
    localparam logic [1:0] MODE_ONES = 2'd3;

    // Widest supported word; callers truncate the result to their own DATA_W.
    localparam int PAT_MAX_W = 64;

    function automatic logic [PAT_MAX_W-1:0] pattern(input logic [1:0]           mode,
                                                     input logic [PAT_MAX_W-1:0] addr);
        case (mode)
            MODE_ADDR: pattern = addr;
            MODE_INV:  pattern = ~addr;
            MODE_CHK:  pattern = addr[0] ? {32{2'b10}} : {32{2'b01}};
            default:   pattern = '1;
        endcase
    endfunction

endpackage

// File: rtl/rd_pacer.sv
// Free-running divider that emits a one-cycle tick every RD_DIV clocks while not cleared.
module rd_pacer #(
    parameter int RD_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST) && !clear;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM exerciser: fills the array with a pattern at one word per clock, then reads it
// back at a paced rate and counts words that differ from the expected pattern.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_DIV = 10_000_000,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic              w_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [RD_LAT-1:0] VLD_TAIL  = RD_LAT'(1) << (RD_LAT - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state, state_nx;
    logic              start_wr_q, start_rd_q, abort_q;
    logic              wr_edge, rd_edge, abort_edge;
    logic              wr_go, rd_go, abort_go;
    logic [1:0]        mode_q;
    logic              tick, pacer_clr;
    logic [DATA_W-1:0] pat;
    logic [RD_LAT-1:0] vld_p;
    logic [DATA_W-1:0] exp_p [RD_LAT];
    logic              drained, cmp_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_wr_q <= 1'b0;
            start_rd_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            start_wr_q <= start_wr;
            start_rd_q <= start_rd;
            abort_q    <= abort;
        end
    end

    assign wr_edge    = start_wr & ~start_wr_q;
    assign rd_edge    = start_rd & ~start_rd_q;
    assign abort_edge = abort & ~abort_q;

    // An abort edge outranks both starts even in IDLE, where it otherwise does nothing.
    assign wr_go    = (state == IDLE) && wr_edge && !abort_edge;
    assign rd_go    = (state == IDLE) && rd_edge && !wr_edge && !abort_edge;
    assign abort_go = abort_edge && busy;

    assign pat     = DATA_W'(pattern(mode_q, PAT_MAX_W'(addr)));
    assign data_in = w_en ? pat : '0;

    assign pacer_clr = (state != READ);

    rd_pacer #(
        .RD_DIV(RD_DIV)
    ) u_pacer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(pacer_clr),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        w_en     = 1'b0;
        rd_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_go) begin
                    state_nx = WRITE;
                end else if (rd_go) begin
                    state_nx = READ;
                end
            end
            WRITE: begin
                w_en = 1'b1;
                busy = 1'b1;
                if (abort_edge) begin
                    state_nx = IDLE;
                end else if (addr == ADDR_LAST) begin
                    state_nx = DONE;
                end
            end
            READ: begin
                rd_en = tick;
                busy  = 1'b1;
                if (abort_edge) begin
                    state_nx = IDLE;
                end else if (tick && addr == ADDR_LAST) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (abort_edge) begin
                    state_nx = IDLE;
                end else if (drained) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The last address rolls over to 0, which is also the value IDLE expects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            mode_q  <= MODE_ADDR;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            if (wr_go || rd_go) begin
                addr    <= '0;
                mode_q  <= mode;
                err     <= 1'b0;
                err_cnt <= '0;
            end else begin
                if (abort_go) begin
                    addr <= '0;
                end else if (w_en || rd_en) begin
                    addr <= addr + ADDR_W'(1);
                end
                if (vld_p[RD_LAT-1] && cmp_bad) begin
                    err     <= 1'b1;
                    err_cnt <= sat_inc(err_cnt);
                end
            end
        end
    end

    // Stages p0..p(RD_LAT-1): expected word travels with the strobe until RAM data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (abort_go) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | RD_LAT'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        exp_p[0] <= pat;
        for (int i = 1; i < RD_LAT; i++) begin
            exp_p[i] <= exp_p[i-1];
        end
    end

    // Compare stage: the last pipeline slot lines up with data_out.
    assign cmp_bad = (data_out != exp_p[RD_LAT-1]);
    assign drained = ((vld_p & ~VLD_TAIL) == '0);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl with a 16-word model RAM (1-cycle read latency).
module tb_ram_bist_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int RD_DIV = 4;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] cnt;
    } rd_exp_t;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start_wr = 1'b0;
    logic              start_rd = 1'b0;
    logic              abort    = 1'b0;
    logic [1:0]        mode     = 2'd0;
    logic              w_en, rd_en, busy, done, err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [15:0]       err_cnt;

    logic [7:0] mem     [DEPTH];
    logic [7:0] written [DEPTH];
    logic       poke      = 1'b0;
    logic [3:0] poke_addr = 4'd0;
    logic [7:0] poke_data = 8'd0;

    wr_exp_t wr_q [$];
    rd_exp_t rd_q [$];
    wr_exp_t wr_e;
    rd_exp_t rd_e;

    int n_cmp = 0;
    int n_bad = 0;

    ram_bist_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .RD_DIV(RD_DIV),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_wr(start_wr),
        .start_rd(start_rd),
        .abort   (abort),
        .mode    (mode),
        .w_en    (w_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) begin
            mem[addr] <= data_in;
        end else if (poke) begin
            mem[poke_addr] <= poke_data;
        end
        if (rd_en) begin
            data_out <= mem[addr];
        end
    end

    function automatic logic [7:0] exp_pat(input logic [1:0] m, input logic [3:0] a);
        case (m)
            2'd0:    return {4'h0, a};
            2'd1:    return ~{4'h0, a};
            2'd2:    return a[0] ? 8'hAA : 8'h55;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(output int gap);
        gap = 0;
        do begin
            step();
            gap++;
        end while (!rd_en && gap < 20);
    endtask

    always @(negedge clk) begin
        if (rst_n && w_en) begin
            if (wr_q.size() == 0) begin
                chk_eq("wr_unexpected_addr", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                wr_e = wr_q.pop_front();
                chk_eq("wr_addr", 32'(addr), 32'(wr_e.addr));
                chk_eq("wr_data", 32'(data_in), 32'(wr_e.data));
            end
        end
        if (rst_n && rd_en) begin
            if (rd_q.size() == 0) begin
                chk_eq("rd_unexpected_addr", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                rd_e = rd_q.pop_front();
                chk_eq("rd_addr", 32'(addr), 32'(rd_e.addr));
                chk_eq("rd_err_cnt", 32'(err_cnt), 32'(rd_e.cnt));
                chk_eq("rd_err", 32'(err), 32'(rd_e.cnt != 16'd0));
            end
        end
    end

    task automatic push_writes(input logic [1:0] m);
        wr_exp_t e;
        for (int a = 0; a < DEPTH; a++) begin
            written[a] = exp_pat(m, 4'(a));
            e.addr     = 4'(a);
            e.data     = exp_pat(m, 4'(a));
            wr_q.push_back(e);
        end
    endtask

    task automatic run_write(input logic [1:0] m, input bit hold);
        int busy_seen;
        push_writes(m);
        mode     = m;
        start_wr = 1'b1;
        step();
        if (!hold) start_wr = 1'b0;
        mode = m ^ 2'b01;
        for (int k = 0; k < DEPTH; k++) begin
            chk_eq("wr_w_en", 32'(w_en), 32'd1);
            if (k < DEPTH - 1) step();
        end
        step();
        chk_eq("wr_done", 32'(done), 32'd1);
        chk_eq("wr_busy_in_done", 32'(busy), 32'd0);
        chk_eq("wr_w_en_in_done", 32'(w_en), 32'd0);
        step();
        chk_eq("wr_done_pulse", 32'(done), 32'd0);
        chk_eq("wr_busy_after", 32'(busy), 32'd0);
        chk_eq("wr_q_left", 32'(wr_q.size()), 32'd0);
        if (hold) begin
            busy_seen = 0;
            repeat (100) begin
                step();
                if (busy) busy_seen++;
            end
            chk_eq("wr_hold_retrigger", 32'(busy_seen), 32'd0);
            start_wr = 1'b0;
        end
    endtask

    task automatic run_read(input logic [1:0] m, input int abort_after);
        int      gap, cnt, idle_done, idle_rd;
        int      pre [DEPTH+1];
        rd_exp_t e;
        cnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            pre[a] = cnt;
            e.addr = 4'(a);
            e.cnt  = 16'(cnt);
            rd_q.push_back(e);
            if (written[a] != exp_pat(m, 4'(a))) cnt++;
        end
        pre[DEPTH] = cnt;
        mode     = m;
        start_rd = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            wait_rd(gap);
            chk_eq("rd_gap", 32'(gap), 32'(RD_DIV));
            if (k == 0) begin
                start_rd = 1'b0;
                mode     = m ^ 2'b11;
            end
            if (k == abort_after) begin
                step();
                step();
                chk_eq("abort_addr_before", 32'(addr), 32'(k + 1));
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk_eq("abort_rd_en", 32'(rd_en), 32'd0);
                chk_eq("abort_addr", 32'(addr), 32'd0);
                chk_eq("abort_busy", 32'(busy), 32'd0);
                idle_done = 0;
                idle_rd   = 0;
                repeat (12) begin
                    step();
                    if (done) idle_done++;
                    if (rd_en) idle_rd++;
                end
                chk_eq("abort_no_done", 32'(idle_done), 32'd0);
                chk_eq("abort_no_rd", 32'(idle_rd), 32'd0);
                chk_eq("abort_err_cnt", 32'(err_cnt), 32'(pre[k+1]));
                chk_eq("abort_err", 32'(err), 32'(pre[k+1] != 0));
                rd_q.delete();
                return;
            end
        end
        gap = 0;
        do begin
            step();
            gap++;
        end while (!done && gap < 10);
        chk_eq("rd_done_lat", 32'(gap), 32'd2);
        chk_eq("rd_final_err_cnt", 32'(err_cnt), 32'(cnt));
        chk_eq("rd_final_err", 32'(err), 32'(cnt != 0));
        chk_eq("rd_busy_in_done", 32'(busy), 32'd0);
        step();
        chk_eq("rd_done_pulse", 32'(done), 32'd0);
        chk_eq("rd_q_left", 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_w_en", 32'(w_en), 32'd0);
        chk_eq("rst_rd_en", 32'(rd_en), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_addr", 32'(addr), 32'd0);
        chk_eq("rst_data_in", 32'(data_in), 32'd0);
        chk_eq("rst_err", 32'(err), 32'd0);
        chk_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        run_write(2'd0, 1'b0);
        run_read(2'd0, -1);

        poke_addr  = 4'd5;
        poke_data  = 8'hFF;
        poke       = 1'b1;
        step();
        poke       = 1'b0;
        written[5] = 8'hFF;
        run_read(2'd0, -1);

        run_write(2'd2, 1'b1);
        run_read(2'd2, -1);
        run_read(2'd1, -1);
        run_read(2'd1, 6);

        push_writes(2'd0);
        mode     = 2'd0;
        start_wr = 1'b1;
        step();
        start_wr = 1'b0;
        repeat (9) step();
        chk_eq("rst_mid_addr_before", 32'(addr), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_mid_w_en", 32'(w_en), 32'd0);
        chk_eq("rst_mid_addr", 32'(addr), 32'd0);
        chk_eq("rst_mid_busy", 32'(busy), 32'd0);
        chk_eq("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        chk_eq("rst_mid_data_in", 32'(data_in), 32'd0);
        wr_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        run_write(2'd0, 1'b0);
        run_read(2'd0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
